// File: rtl/fila_pkg.sv
`timescale 1us/1ns
// fila_pkg: shared state encoding and sizes for the fila byte-queue arbiter.
package fila_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ENQ       = 3'd1,
      DEQ_SEL   = 3'd2,
      DEQ_SHIFT = 3'd3,
      DEQ_ACK   = 3'd4
   } arb_state_t;

   localparam int FILA_DEPTH = 8;
   localparam int FILA_DW    = 8;

   // Round-robin pointer that follows a grant to idx, wrapping modulo n.
   function automatic logic [7:0] rr_next(input logic [7:0] idx, input int n);
      return (int'(idx) >= n - 1) ? 8'd0 : idx + 8'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
`timescale 1us/1ns
// rr_pick: combinational round-robin select; the first requester at or after ptr
// (wrapping modulo N_PROD) wins.
module rr_pick #(
   parameter int N_PROD = 2,
   parameter int IW     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic [N_PROD-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic [N_PROD-1:0] grant,
   output logic [IW-1:0]     idx,
   output logic              any
);

   // Scan from the farthest candidate back to ptr so the nearest requester is kept last.
   always_comb begin
      int cand;
      cand = 0;
      idx  = '0;
      any  = |req;
      for (int k = N_PROD - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N_PROD;
         idx  = req[cand] ? IW'(cand) : idx;
      end
      grant = any ? (N_PROD'(1) << idx) : '0;
   end

endmodule

// File: rtl/fila_arbiter.sv
`timescale 1us/1ns
// fila_arbiter: serialises round-robin producer enqueues and single-consumer dequeues
// onto the fila byte queue. Define FILA_ARBITER_CHECK_EN to add the sticky len_err check.
module fila_arbiter
   import fila_pkg::*;
#(
   parameter int N_PROD = 2,
   parameter int DW     = FILA_DW,
   parameter int DEPTH  = FILA_DEPTH
) (
   input  logic                 clk_10KHz,
   input  logic                 reset,
   input  logic [N_PROD-1:0]    prod_valid,
   input  logic [N_PROD*DW-1:0] prod_data,
   output logic [N_PROD-1:0]    prod_ready,
   input  logic                 cons_req,
   output logic                 cons_ack,
   output logic [DW-1:0]        cons_data,
   output logic                 q_enqueue,
   output logic                 q_dequeue,
   output logic [DW-1:0]        q_data,
   input  logic [DW-1:0]        q_data_out,
   input  logic [7:0]           q_len,
   output logic [7:0]           count,
   output logic                 full,
`ifdef FILA_ARBITER_CHECK_EN
   output logic                 empty,
   output logic                 len_err
`else
   output logic                 empty
`endif
);

   localparam int         IW      = (N_PROD > 1) ? $clog2(N_PROD) : 1;
   localparam logic [7:0] DEPTH_C = 8'(DEPTH);

   arb_state_t        state_r, state_s;
   logic [IW-1:0]     rr_ptr_r, rr_ptr_s;
   logic              last_was_deq_r, last_was_deq_s;
   logic [7:0]        count_r, count_s;
   logic [N_PROD-1:0] prod_ready_r, prod_ready_s;
   logic              q_enqueue_r, q_enqueue_s;
   logic              q_dequeue_r, q_dequeue_s;
   logic [DW-1:0]     q_data_r, q_data_s;
   logic [DW-1:0]     cons_data_r, cons_data_s;
   logic              cons_ack_r, cons_ack_s;
   logic              full_r, full_s;
   logic              empty_r, empty_s;

   logic [N_PROD-1:0] pick_grant_s;
   logic [IW-1:0]     pick_idx_s;
   logic              pick_any_s;
   logic              enq_ok_s;
   logic              deq_ok_s;

   rr_pick #(
      .N_PROD (N_PROD),
      .IW     (IW)
   ) u_rr_pick (
      .req   (prod_valid),
      .ptr   (rr_ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   assign enq_ok_s = pick_any_s & ~full_r;
   assign deq_ok_s = cons_req & ~empty_r;

   // Next state and next registered outputs; the winner is latched on the way into ENQ.
   always_comb begin
      state_s        = state_r;
      rr_ptr_s       = rr_ptr_r;
      last_was_deq_s = last_was_deq_r;
      count_s        = count_r;
      prod_ready_s   = '0;
      q_enqueue_s    = 1'b0;
      q_dequeue_s    = 1'b0;
      q_data_s       = '0;
      cons_data_s    = cons_data_r;
      cons_ack_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (enq_ok_s && (!deq_ok_s || last_was_deq_r)) begin
               state_s      = ENQ;
               prod_ready_s = pick_grant_s;
               q_enqueue_s  = 1'b1;
               q_data_s     = prod_data[int'(pick_idx_s)*DW +: DW];
               rr_ptr_s     = IW'(rr_next(8'(pick_idx_s), N_PROD));
            end else if (deq_ok_s) begin
               state_s     = DEQ_SEL;
               q_dequeue_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         ENQ: begin
            state_s        = IDLE;
            last_was_deq_s = 1'b0;
            count_s        = full_r ? count_r : count_r + 8'd1;
         end
         DEQ_SEL: begin
            state_s = DEQ_SHIFT;
         end
         DEQ_SHIFT: begin
            // The queue presents the selected head while it shifts.
            state_s     = DEQ_ACK;
            cons_data_s = q_data_out;
            cons_ack_s  = 1'b1;
         end
         DEQ_ACK: begin
            state_s        = IDLE;
            last_was_deq_s = 1'b1;
            count_s        = empty_r ? count_r : count_r - 8'd1;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      full_s  = (count_s == DEPTH_C);
      empty_s = (count_s == 8'd0);
   end

   // State, occupancy and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         rr_ptr_r       <= '0;
         last_was_deq_r <= 1'b0;
         count_r        <= 8'd0;
         prod_ready_r   <= '0;
         q_enqueue_r    <= 1'b0;
         q_dequeue_r    <= 1'b0;
         q_data_r       <= '0;
         cons_data_r    <= '0;
         cons_ack_r     <= 1'b0;
         full_r         <= 1'b0;
         empty_r        <= 1'b1;
      end else begin
         state_r        <= state_s;
         rr_ptr_r       <= rr_ptr_s;
         last_was_deq_r <= last_was_deq_s;
         count_r        <= count_s;
         prod_ready_r   <= prod_ready_s;
         q_enqueue_r    <= q_enqueue_s;
         q_dequeue_r    <= q_dequeue_s;
         q_data_r       <= q_data_s;
         cons_data_r    <= cons_data_s;
         cons_ack_r     <= cons_ack_s;
         full_r         <= full_s;
         empty_r        <= empty_s;
      end
   end

   assign prod_ready = prod_ready_r;
   assign q_enqueue  = q_enqueue_r;
   assign q_dequeue  = q_dequeue_r;
   assign q_data     = q_data_r;
   assign cons_data  = cons_data_r;
   assign cons_ack   = cons_ack_r;
   assign count      = count_r;
   assign full       = full_r;
   assign empty      = empty_r;

`ifdef FILA_ARBITER_CHECK_EN
   logic len_err_r;

   // Sticky mismatch flag; q_len trails the arbiter by one state, so compare only in IDLE.
   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         len_err_r <= 1'b0;
      end else if ((state_r == IDLE) && (q_len != count_r)) begin
         len_err_r <= 1'b1;
      end else begin
         len_err_r <= len_err_r;
      end
   end

   assign len_err = len_err_r;
`else
   logic unused_q_len;
   assign unused_q_len = ^q_len;
`endif

endmodule

// File: tb/tb_fila_arbiter.sv
`timescale 1us/1ns
// tb_fila_arbiter: scoreboard bench with directed and random traffic; a behavioural
// 8-entry byte queue stands in for fila.
module tb_fila_arbiter;

   localparam int NP    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic             clk_10KHz = 1'b0;
   logic             reset = 1'b0;
   logic [NP-1:0]    prod_valid = '0;
   logic [NP*DW-1:0] prod_data = '0;
   logic [NP-1:0]    prod_ready;
   logic             cons_req = 1'b0;
   logic             cons_ack;
   logic [DW-1:0]    cons_data;
   logic             q_enqueue;
   logic             q_dequeue;
   logic [DW-1:0]    q_data;
   logic [DW-1:0]    q_data_out;
   logic [7:0]       q_len;
   logic [7:0]       count;
   logic             full;
   logic             empty;
`ifdef FILA_ARBITER_CHECK_EN
   logic             len_err;
`endif

   fila_arbiter #(.N_PROD(NP), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk_10KHz  (clk_10KHz),
      .reset      (reset),
      .prod_valid (prod_valid),
      .prod_data  (prod_data),
      .prod_ready (prod_ready),
      .cons_req   (cons_req),
      .cons_ack   (cons_ack),
      .cons_data  (cons_data),
      .q_enqueue  (q_enqueue),
      .q_dequeue  (q_dequeue),
      .q_data     (q_data),
      .q_data_out (q_data_out),
      .q_len      (q_len),
      .count      (count),
      .full       (full),
`ifdef FILA_ARBITER_CHECK_EN
      .empty      (empty),
      .len_err    (len_err)
`else
      .empty      (empty)
`endif
   );

   always #50 clk_10KHz = ~clk_10KHz;

   // Byte queue: enqueue appends, dequeue registers the head onto data_out and shifts.
   logic [DW-1:0] qmem [DEPTH];
   int            qlen;
   assign q_len = 8'(qlen);
   always @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         qlen       <= 0;
         q_data_out <= '0;
      end else if (q_dequeue && qlen > 0) begin
         q_data_out <= qmem[0];
         for (int i = 0; i < DEPTH - 1; i++) qmem[i] <= qmem[i+1];
         qlen <= qlen - 1;
      end else if (q_enqueue && qlen < DEPTH) begin
         qmem[qlen] <= q_data;
         qlen       <= qlen + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state (transaction level).
   logic [DW-1:0] exp_q[$];
   int            gseq[$];
   int            m_count = 0;
   int            m_ptr = 0;
   bit            m_last_deq = 1'b0;
   int            cyc = 0;
   int            stall = 0;
   int            grant_cnt[NP];
   int            last_grant_cyc[NP];
   int            last_ack_cyc = 0;
   int            ack_cnt = 0;
   int            deq_cnt = 0;
   int            n_contested = 0;

   // Monitor / scoreboard.
   initial begin
      forever begin
         @(negedge clk_10KHz);
         cyc++;
         if (reset) begin
            exp_q.delete();
            m_count    = 0;
            m_ptr      = 0;
            m_last_deq = 1'b0;
            stall      = 0;
         end else begin
            int w;
            int exp_op;
            bit eok;
            bit dok;
            eok = (|prod_valid) && (m_count < DEPTH);
            dok = cons_req && (m_count > 0);
            check("count", 32'(count), 32'(m_count));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("empty", 32'(empty), 32'(m_count == 0));
            check("enq_deq_overlap", 32'(q_enqueue & q_dequeue), 32'd0);
            if (q_dequeue) deq_cnt++;
            if (q_enqueue || q_dequeue) begin
               exp_op = (eok && dok) ? (m_last_deq ? 1 : 2) : (eok ? 1 : (dok ? 2 : 0));
               if (eok && dok) n_contested++;
               check("op_choice", q_enqueue ? 32'd1 : 32'd2, 32'(exp_op));
            end
            if (prod_ready != '0) begin
               w = -1;
               for (int k = 0; k < NP; k++)
                  if (w < 0 && prod_valid[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
               check("grant_while_full", 32'(m_count < DEPTH), 32'd1);
               if (w >= 0) begin
                  check("grant_rr", 32'(prod_ready), 32'(1) << w);
                  check("q_enqueue_with_grant", 32'(q_enqueue), 32'd1);
                  check("q_data", 32'(q_data), 32'(prod_data[w*DW +: DW]));
                  exp_q.push_back(prod_data[w*DW +: DW]);
                  gseq.push_back(w);
                  grant_cnt[w]++;
                  last_grant_cyc[w] = cyc;
                  m_ptr = (w + 1) % NP;
               end else begin
                  check("grant_without_valid", 32'(prod_ready), 32'd0);
               end
               m_count++;
               m_last_deq = 1'b0;
            end else begin
               check("q_enqueue_without_grant", 32'(q_enqueue), 32'd0);
            end
            if (cons_ack) begin
               if (exp_q.size() == 0) check("ack_on_empty", 32'(cons_ack), 32'd0);
               else check("cons_data", 32'(cons_data), 32'(exp_q.pop_front()));
               m_count      = (m_count > 0) ? m_count - 1 : 0;
               m_last_deq   = 1'b1;
               last_ack_cyc = cyc;
               ack_cnt++;
            end
            if (prod_ready != '0 || cons_ack || !(eok || dok)) stall = 0;
            else stall++;
            if (stall > 8) begin
               n_cmp++;
               n_bad++;
               $display("FAIL progress_bound: %0d cycles without grant/ack, expected <= 8", stall);
               stall = 0;
            end
         end
      end
   end

   // Producer/consumer drivers: bytes held until granted, requests held until acked.
   logic [DW-1:0] pq[NP][$];
   int            cons_pend = 0;
   initial begin
      forever begin
         @(negedge clk_10KHz);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (prod_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (pq[i].size() > 0) begin
               prod_valid[i]         = 1'b1;
               prod_data[i*DW +: DW] = pq[i][0];
            end else begin
               prod_valid[i]         = 1'b0;
               prod_data[i*DW +: DW] = '0;
            end
         end
         if (cons_ack && cons_pend > 0) cons_pend--;
         cons_req = (cons_pend > 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_10KHz);
      #2;
   endtask

   function automatic int pending();
      int s = cons_pend;
      for (int i = 0; i < NP; i++) s += pq[i].size();
      return s;
   endfunction

   task automatic drain(input string name);
      int n = 0;
      while (pending() > 0 && n < 3000) begin
         @(negedge clk_10KHz);
         n++;
      end
      if (n >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_%s: %0d items still pending after %0d cycles", name, pending(), n);
      end
      tick(2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int found;
      int a0;
      int d0;
      int pushed;
      int issued;
      #5 reset = 1'b1;
      #10;
      check("rst_prod_ready", 32'(prod_ready), 32'd0);
      check("rst_cons_ack", 32'(cons_ack), 32'd0);
      check("rst_cons_data", 32'(cons_data), 32'd0);
      check("rst_q_enqueue", 32'(q_enqueue), 32'd0);
      check("rst_q_dequeue", 32'(q_dequeue), 32'd0);
      check("rst_q_data", 32'(q_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      tick(2);
      reset = 1'b0;
      tick(2);

      // 1: three bytes from P0
      pq[0].push_back(8'h11);
      pq[0].push_back(8'h22);
      pq[0].push_back(8'h33);
      drain("t1");
      check("t1_count", 32'(count), 32'd3);
      check("t1_q_len", 32'(q_len), 32'd3);
      check("t1_p0_grants", 32'(grant_cnt[0]), 32'd3);

      // 2: P0 and P1 contend continuously
      gseq.delete();
      pq[0].push_back(8'hA0);
      pq[0].push_back(8'hA1);
      pq[1].push_back(8'hB0);
      pq[1].push_back(8'hB1);
      drain("t2");
      check("t2_grants", 32'(gseq.size()), 32'd4);
      for (int k = 1; k < 4 && k < gseq.size(); k++)
         check("t2_alternate", 32'(gseq[k] != gseq[k-1]), 32'd1);

      // 3: fill to 8, stall, one dequeue releases the stalled producer
      pq[0].push_back(8'h3C);
      pq[1].push_back(8'h3D);
      tick(12);
      check("t3_full", 32'(full), 32'd1);
      check("t3_count", 32'(count), 32'd8);
      check("t3_stalled", 32'(pq[0].size() + pq[1].size()), 32'd1);
      cons_pend = 1;
      drain("t3a");
      check("t3_first_byte", 32'(cons_data), 32'h11);
      check("t3_refill", 32'(count), 32'd8);
      cons_pend = 8;
      drain("t3b");
      check("t3_empty", 32'(empty), 32'd1);

      // 4: consumer waits on empty, then a P1 byte passes straight through
      a0 = ack_cnt;
      d0 = deq_cnt;
      cons_pend = 1;
      tick(10);
      check("t4_no_ack", 32'(ack_cnt), 32'(a0));
      check("t4_no_dequeue", 32'(deq_cnt), 32'(d0));
      pq[1].push_back(8'h5C);
      drain("t4");
      check("t4_data", 32'(cons_data), 32'h5C);
      check("t4_latency", 32'(last_ack_cyc - last_grant_cyc[1]), 32'd4);

      // 5: producer and consumer active together on a non-empty queue
      pq[2].push_back(8'h50);
      pq[2].push_back(8'h51);
      drain("t5a");
      n_contested = 0;
      for (int k = 0; k < 6; k++) pq[0].push_back(8'(8'h60 + k));
      cons_pend = 6;
      drain("t5b");
      check("t5_contested", 32'(n_contested > 0), 32'd1);
      cons_pend = 2;
      drain("t5c");

      // Random traffic; requests never outnumber bytes offered
      pushed = 0;
      issued = 0;
      for (int c = 0; c < 500; c++) begin
         int p;
         @(negedge clk_10KHz);
         #2;
         p = int'($urandom_range(0, NP - 1));
         if ($urandom_range(0, 2) == 0 && pq[p].size() < 3) begin
            pq[p].push_back(8'($urandom));
            pushed++;
         end
         if ($urandom_range(0, 3) == 0 && issued < pushed) begin
            cons_pend++;
            issued++;
         end
      end
      cons_pend += pushed - issued;
      drain("rand");
      check("rand_empty", 32'(count), 32'd0);

      // 6: reset while the queue is shifting
      pq[0].push_back(8'h71);
      pq[0].push_back(8'h72);
      drain("t6a");
      cons_pend = 1;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge clk_10KHz);
         if (q_dequeue) found = 1;
      end
      check("t6_saw_dequeue", 32'(found), 32'd1);
      @(negedge clk_10KHz);
      #2;
      reset = 1'b1;
      cons_pend = 0;
      for (int i = 0; i < NP; i++) pq[i].delete();
      prod_valid = '0;
      cons_req = 1'b0;
      #1;
      check("t6_count", 32'(count), 32'd0);
      check("t6_empty", 32'(empty), 32'd1);
      check("t6_full", 32'(full), 32'd0);
      check("t6_no_ack", 32'(cons_ack), 32'd0);
      check("t6_no_dequeue", 32'(q_dequeue), 32'd0);
      a0 = ack_cnt;
      tick(1);
      reset = 1'b0;
      tick(6);
      check("t6_no_late_ack", 32'(ack_cnt), 32'(a0));
      pq[1].push_back(8'h77);
      cons_pend = 1;
      drain("t6b");
      check("t6_post_reset_data", 32'(cons_data), 32'h77);
`ifdef FILA_ARBITER_CHECK_EN
      check("len_err", 32'(len_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
